// File: rtl/uart_tx_sched_if.sv
// Requester/transmitter bundle for uart_tx_sched: two byte requesters, baud divisor,
// and the parallel-load transmitter handshake. Signal names follow the block's port list.
interface uart_tx_sched_if;
  logic [15:0] div;
  logic        req0_valid;
  logic [7:0]  req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [7:0]  req1_data;
  logic        req1_ready;
  logic        tx_ts;
  logic        tx_load;
  logic [7:0]  tx_d;
  logic        tx_en;
  logic        busy;
  logic        grant_id;

  modport master (
    output div, req0_valid, req0_data, req1_valid, req1_data, tx_ts,
    input  req0_ready, req1_ready, tx_load, tx_d, tx_en, busy, grant_id
  );

  modport slave (
    input  div, req0_valid, req0_data, req1_valid, req1_data, tx_ts,
    output req0_ready, req1_ready, tx_load, tx_d, tx_en, busy, grant_id
  );
endinterface

// File: rtl/uart_tx_sched.sv
// Two-requester UART transmit scheduler with baud tick generator.
// Define UART_TX_RR_EN for round-robin arbitration; default is fixed priority (requester 0).
//
// state     | meaning
// IDLE      | waiting for a valid requester while the transmitter reports idle
// LOAD      | tx_load strobe high for one cycle with tx_d holding the accepted byte
// WAIT_BUSY | waiting for the transmitter to report busy
// WAIT_DONE | waiting for the transmitter to report idle again
module uart_tx_sched (
  input  logic           clk,
  input  logic           rst,
  uart_tx_sched_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE} state_t;

  state_t      r_state;
  logic [15:0] r_cnt;
  logic        r_tx_en;
  logic        r_tx_load;
  logic [7:0]  r_tx_d;
  logic        r_grant;

  logic        w_win;
  logic        w_win_valid;
  logic [7:0]  w_win_data;
  logic        w_acc;

  always_comb begin
    w_win = ~bus.req0_valid;
`ifdef UART_TX_RR_EN
    if (bus.req0_valid && bus.req1_valid)
      w_win = ~r_grant;
`endif
    w_win_valid = w_win ? bus.req1_valid : bus.req0_valid;
    w_win_data  = w_win ? bus.req1_data  : bus.req0_data;
    w_acc       = (r_state == IDLE) && bus.tx_ts && w_win_valid;
  end

  assign bus.req0_ready = w_acc && !w_win;
  assign bus.req1_ready = w_acc &&  w_win;
  assign bus.tx_load    = r_tx_load;
  assign bus.tx_d       = r_tx_d;
  assign bus.tx_en      = r_tx_en;
  assign bus.busy       = (r_state != IDLE);
  assign bus.grant_id   = r_grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_tx_load <= 1'b0;
      r_tx_d    <= 8'h00;
      r_grant   <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_acc) begin
            r_tx_d    <= w_win_data;
            r_tx_load <= 1'b1;
            r_grant   <= w_win;
            r_state   <= LOAD;
          end
        end
        LOAD: begin
          r_tx_load <= 1'b0;
          r_state   <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!bus.tx_ts)
            r_state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (bus.tx_ts)
            r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Restarting on accept gives the first bit a full period; a count left above a
  // freshly lowered divisor is dropped silently rather than producing a tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= 16'h0000;
      r_tx_en <= 1'b0;
    end else if (w_acc) begin
      r_cnt   <= 16'h0000;
      r_tx_en <= 1'b0;
    end else if (r_cnt == bus.div) begin
      r_cnt   <= 16'h0000;
      r_tx_en <= 1'b1;
    end else if (r_cnt > bus.div) begin
      r_cnt   <= 16'h0000;
      r_tx_en <= 1'b0;
    end else begin
      r_cnt   <= r_cnt + 16'd1;
      r_tx_en <= 1'b0;
    end
  end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter: none; baud divisor is a runtime input.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 div  input  16  baud divisor; tx_en period = div+1 clk cycles.
REQ-005 req0_valid  input  1  requester 0 has a byte to send.
REQ-006 req0_data  input  8  requester 0 byte.
REQ-007 req0_ready  output  1  requester 0 byte accepted this cycle when req0_valid is also high.
REQ-008 req1_valid / req1_data / req1_ready  same widths and meaning for requester 1.
REQ-009 tx_ts  input  1  transmitter status; 1 = transmitter idle.
REQ-010 tx_load  output  1  one-cycle parallel-load strobe to the transmitter.
REQ-011 tx_d  output  8  byte presented to the transmitter; valid while tx_load=1.
REQ-012 tx_en  output  1  one-cycle bit-period tick to the transmitter.
REQ-013 busy  output  1  1 in any state other than IDLE.
REQ-014 grant_id  output  1  index of the most recently accepted requester.

Function
REQ-015 FSM states IDLE, LOAD, WAIT_BUSY, WAIT_DONE; reset state IDLE.
REQ-016 IDLE: reqN_ready is combinational and high only for the arbitration winner, only when tx_ts=1 and that reqN_valid=1; at most one ready is high per cycle.
REQ-017 Accept edge (IDLE, winner valid&ready): tx_d <= winner data, tx_load <= 1, grant_id <= winner, FSM -> LOAD.
REQ-018 LOAD: tx_load=1 for exactly this one cycle; next edge tx_load <= 0, FSM -> WAIT_BUSY.
REQ-019 WAIT_BUSY: stay until tx_ts=0, then -> WAIT_DONE; no ready asserted.
REQ-020 WAIT_DONE: stay until tx_ts=1, then -> IDLE; a new accept can occur in the first IDLE cycle.
REQ-021 Latency: accept at edge N -> tx_load high during cycle N+1 -> byte enters transmitter at edge N+2.
REQ-022 tx_d holds its value from accept until the next accept.
REQ-023 Baud counter: 16-bit; tx_en=1 when counter==div, and counter wraps to 0 on that edge; otherwise counter increments.
REQ-024 div=0: tx_en high every cycle; div=16'hFFFF: period 65536 cycles, no overflow.
REQ-025 Baud counter is cleared to 0 on the accept edge, so the first bit period after a load is a full div+1 cycles.
REQ-026 div changed mid-count: if counter > new div, counter wraps to 0 on the next edge without pulsing tx_en.
REQ-027 IDLE with tx_ts=0 (transmitter busy from outside): no ready asserted; FSM stays IDLE.
REQ-028 Valid deasserted before accept: no transfer; requester may drop valid at any time without side effect.

Reset
REQ-029 On rst: FSM=IDLE, tx_load=0, tx_d=8'h00, tx_en=0, baud counter=0, grant_id=1 (so requester 0 wins first under round-robin), busy=0.
REQ-030 rst mid-frame: all of the above take effect immediately (asynchronously); no partial tx_load pulse survives reset.

Configuration
REQ-031 Macro UART_TX_RR_EN defined: round-robin; when both valid, the winner is the requester other than grant_id.
REQ-032 UART_TX_RR_EN undefined: fixed priority; requester 0 always wins when req0_valid=1; grant_id still tracks the accepted requester.

Verification
REQ-033 Single byte: div=3, tx_ts=1, req0_valid=1, data=8'hA5 -> req0_ready=1 for one cycle; tx_load=1 next cycle with tx_d=8'hA5; tx_en pulses every 4 cycles after the accept.
REQ-034 Contention with UART_TX_RR_EN: both valid continuously, data 8'h11 / 8'h22, transmitter model returning tx_ts=1 after 10 ticks -> loads alternate 11,22,11,22 starting with 11.
REQ-035 Contention without the macro: same stimulus -> every load is 8'h11; req1_ready never asserted.
REQ-036 Handshake stall: tx_ts held 0 in IDLE with req1_valid=1 -> no ready and no tx_load until tx_ts=1; then accept next cycle.
REQ-037 div boundaries: div=0 -> tx_en constant 1; div changed from 100 to 5 while counter=50 -> counter wraps to 0 with no tx_en pulse, then period 6.
REQ-038 Reset mid-frame: assert rst while in WAIT_DONE -> busy=0, tx_load=0, tx_en=0 immediately; after release, first accept goes to requester 0.
